gshare_branch_predictor: RTL

- Parametrised successor to the 7-entry majority-vote predictor.
- Holds a table of 2^INDEX_W saturating counters, indexed by the PC XORed with a global taken/not-taken history register (gshare).
- Sits between fetch (prediction requests) and execute (branch resolution).
- Adds a registered request/response path, per-branch counters, a post-reset table-initialisation sequence, and optional performance counters.

---
 rtl/gshare_pkg.sv | 33 +++
 rtl/gshare_branch_predictor_if.sv | 49 ++++
 rtl/gshare_counter_table.sv | 37 +++
 rtl/gshare_branch_predictor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gshare_pkg.sv
// gshare_pkg: shared types and counter helpers for the gshare predictor.
// Helpers take the counter width as an argument so any CTR_W up to CTR_W_MAX works.
package gshare_pkg;

   localparam int CTR_W_MAX = 8;

   typedef logic [CTR_W_MAX-1:0] ctr_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic ctr_t ctr_max(int w);
      return ctr_t'((1 << w) - 1);
   endfunction

   function automatic ctr_t ctr_weak_taken(int w);
      return ctr_t'(1 << (w - 1));
   endfunction

   function automatic ctr_t sat_next(ctr_t ctr, logic taken, int w);
      ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ctr_max(w)) nxt = ctr + 1'b1;
      end else begin
         if (ctr != '0) nxt = ctr - 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if: fetch/execute side bundle of the predictor.
// master = fetch/execute, slave = predictor; counts exist with GSHARE_PERF_COUNTERS_EN.
interface gshare_branch_predictor_if #(
   parameter int PC_W    = 32,
   parameter int INDEX_W = 6
);

   logic               ready;
   logic               predict_valid;
   logic [PC_W-1:0]    predict_pc;
   logic               prediction_valid;
   logic               prediction_taken;
   logic [INDEX_W-1:0] prediction_index;
   logic               resolve_valid;
   logic [INDEX_W-1:0] resolve_index;
   logic               resolve_taken;
   logic               resolve_predicted;
`ifdef GSHARE_PERF_COUNTERS_EN
   logic [31:0]        pred_count;
   logic [31:0]        mispred_count;

   modport master (
      input  ready, prediction_valid, prediction_taken, prediction_index,
      input  pred_count, mispred_count,
      output predict_valid, predict_pc,
      output resolve_valid, resolve_index, resolve_taken, resolve_predicted
   );

   modport slave (
      output ready, prediction_valid, prediction_taken, prediction_index,
      output pred_count, mispred_count,
      input  predict_valid, predict_pc,
      input  resolve_valid, resolve_index, resolve_taken, resolve_predicted
   );
`else
   modport master (
      input  ready, prediction_valid, prediction_taken, prediction_index,
      output predict_valid, predict_pc,
      output resolve_valid, resolve_index, resolve_taken, resolve_predicted
   );

   modport slave (
      output ready, prediction_valid, prediction_taken, prediction_index,
      input  predict_valid, predict_pc,
      input  resolve_valid, resolve_index, resolve_taken, resolve_predicted
   );
`endif

endinterface

// File: rtl/gshare_counter_table.sv
// gshare_counter_table: 2^INDEX_W counters, one write port, a raw read for
// read-modify-write and a write-first read port (rdata sees same-cycle write).
module gshare_counter_table
   import gshare_pkg::*;
#(
   parameter int INDEX_W = 6,
   parameter int CTR_W   = 2
) (
   input  logic               clk,
   input  logic               we,
   input  logic [INDEX_W-1:0] waddr,
   input  logic [CTR_W-1:0]   wdata,
   input  logic [INDEX_W-1:0] raddr,
   output logic [CTR_W-1:0]   rdata,
   input  logic [INDEX_W-1:0] rmw_addr,
   output logic [CTR_W-1:0]   rmw_data
);

   localparam int DEPTH = 1 << INDEX_W;

   logic [CTR_W-1:0] mem_q [DEPTH];
   logic [CTR_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Contents are defined by the init sweep, so no reset here.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rmw_data = mem_q[rmw_addr];
   assign rdata    = (we && (waddr == raddr)) ? wdata : mem_q[raddr];

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: PC^history indexed counters, registered prediction, init sweep.
// Ports: clk, rst (sync high), bp (slave); GSHARE_PERF_COUNTERS_EN adds the counts.
module gshare_branch_predictor
   import gshare_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int INDEX_W = 6,
   parameter int HIST_W  = 6,
   parameter int CTR_W   = 2
) (
   input  logic clk,
   input  logic rst,
   gshare_branch_predictor_if.slave bp
);

   localparam logic [CTR_W-1:0] WEAK_T = CTR_W'(ctr_weak_taken(CTR_W));

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] ptr_q, ptr_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic               pv_q, pv_d;
   logic               pt_q, pt_d;
   logic [INDEX_W-1:0] pidx_q, pidx_d;

   logic               run;
   logic               req;
   logic               res;
   logic [INDEX_W-1:0] hist_ext;
   logic [INDEX_W-1:0] pred_idx;
   logic               tbl_we;
   logic [INDEX_W-1:0] tbl_waddr;
   logic [CTR_W-1:0]   tbl_wdata;
   logic [CTR_W-1:0]   tbl_rdata;
   logic [CTR_W-1:0]   rmw_data;

   assign run = (state_q == RUN);
   assign req = run & bp.predict_valid;
   assign res = run & bp.resolve_valid;

   always_comb begin
      hist_ext = '0;
      hist_ext[HIST_W-1:0] = hist_q;
   end

   assign pred_idx = bp.predict_pc[INDEX_W+1:2] ^ hist_ext;

   gshare_counter_table #(
      .INDEX_W (INDEX_W),
      .CTR_W   (CTR_W)
   ) u_table (
      .clk      (clk),
      .we       (tbl_we),
      .waddr    (tbl_waddr),
      .wdata    (tbl_wdata),
      .raddr    (pred_idx),
      .rdata    (tbl_rdata),
      .rmw_addr (bp.resolve_index),
      .rmw_data (rmw_data)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hist_d    = hist_q;
      tbl_we    = 1'b0;
      tbl_waddr = ptr_q;
      tbl_wdata = WEAK_T;
      unique case (state_q)
         INIT: begin
            tbl_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (&ptr_q) state_d = RUN;
         end
         RUN: begin
            if (res) begin
               tbl_we    = 1'b1;
               tbl_waddr = bp.resolve_index;
               tbl_wdata = CTR_W'(sat_next(ctr_t'(rmw_data),
                                           bp.resolve_taken, CTR_W));
               hist_d    = {hist_q[HIST_W-2:0], bp.resolve_taken};
            end
         end
         default: state_d = INIT;
      endcase
      if (rst) tbl_we = 1'b0;
   end

   always_comb begin
      pv_d   = req;
      pt_d   = pt_q;
      pidx_d = pidx_q;
      if (req) begin
         pt_d   = tbl_rdata[CTR_W-1];
         pidx_d = pred_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
         hist_q  <= '0;
         pv_q    <= 1'b0;
         pt_q    <= 1'b0;
         pidx_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hist_q  <= hist_d;
         pv_q    <= pv_d;
         pt_q    <= pt_d;
         pidx_q  <= pidx_d;
      end
   end

   assign bp.ready            = run;
   assign bp.prediction_valid = pv_q;
   assign bp.prediction_taken = pt_q;
   assign bp.prediction_index = pidx_q;

   // PC bits outside the index field never affect the prediction.
   logic unused_pc;
   assign unused_pc = ^{bp.predict_pc[PC_W-1:INDEX_W+2], bp.predict_pc[1:0]};

`ifdef GSHARE_PERF_COUNTERS_EN
   logic [31:0] pcnt_q, pcnt_d;
   logic [31:0] mcnt_q, mcnt_d;
   logic        mis;

   assign mis = res & (bp.resolve_taken != bp.resolve_predicted);

   always_comb begin
      pcnt_d = pcnt_q;
      mcnt_d = mcnt_q;
      if (req && !(&pcnt_q)) pcnt_d = pcnt_q + 1'b1;
      if (mis && !(&mcnt_q)) mcnt_d = mcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign bp.pred_count    = pcnt_q;
   assign bp.mispred_count = mcnt_q;
`else
   logic unused_pred;
   assign unused_pred = bp.resolve_predicted;
`endif

endmodule
